// File: rtl/cacheline_adaptor.sv
// Turns a single-cycle 256-bit cache-line request into a 4-beat, 64-bit memory burst
// and returns the assembled line with a one-cycle response pulse.
module cacheline_adaptor #(
  parameter int DATA_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   line_addr,
  input  logic          line_read,
  input  logic          line_write,
  input  logic [255:0]  line_wdata,
  output logic [255:0]  line_rdata,
  output logic          line_resp,
  output logic [31:0]   bmem_addr,
  output logic          bmem_read,
  output logic          bmem_write,
  output logic [63:0]   bmem_wdata,
  input  logic          bmem_ready,
  input  logic [31:0]   bmem_raddr,
  input  logic [63:0]   bmem_rdata,
  input  logic          bmem_rvalid
);

  localparam int BEATS = 256 / DATA_W;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic [255:0]      wdata_q;
  logic              beat_hit;
  logic              last_beat;

  // Only beats tagged with our own line address belong to this burst.
  assign beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign bmem_addr = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (line_read)       state_nxt = RD_REQ;
        else if (line_write) state_nxt = WR;
      end
      RD_REQ:  if (bmem_ready) state_nxt = RD_DATA;
      RD_DATA: if (beat_hit && last_beat) state_nxt = DONE;
      WR:      if (bmem_ready && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_resp  = 1'b0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    unique case (state)
      RD_REQ:  bmem_read  = 1'b1;
      WR:      bmem_write = 1'b1;
      DONE:    line_resp  = 1'b1;
      default: ;
    endcase
  end

  // Write beat is selected straight from the latched line by the beat counter.
  always_comb begin
    bmem_wdata = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (cnt == CNT_W'(i)) bmem_wdata = wdata_q[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (line_read || line_write) begin
            cnt    <= '0;
            addr_q <= {line_addr[31:5], 5'b0};
            if (!line_read) wdata_q <= line_wdata;
          end
        end
        RD_DATA: begin
          if (beat_hit) begin
            for (int i = 0; i < BEATS; i++) begin
              if (cnt == CNT_W'(i)) line_rdata[i*DATA_W +: DATA_W] <= bmem_rdata;
            end
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (bmem_ready) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, backpressured writes, read/write priority,
// stray-beat filtering, asynchronous reset mid-burst and single-issue of bursts.
module tb_cacheline_adaptor;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   line_addr;
  logic          line_read;
  logic          line_write;
  logic [255:0]  line_wdata;
  logic [255:0]  line_rdata;
  logic          line_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [63:0]   bmem_wdata;
  logic          bmem_ready;
  logic [31:0]   bmem_raddr;
  logic [63:0]   bmem_rdata;
  logic          bmem_rvalid;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_bursts = 0;
  int wr_beats = 0;

  cacheline_adaptor #(.DATA_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .line_addr   (line_addr),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  // Accepted read commands and accepted write beats, as memory sees them.
  always @(posedge clk) begin
    if (bmem_read && bmem_ready)  rd_bursts <= rd_bursts + 1;
    if (bmem_write && bmem_ready) wr_beats  <= wr_beats + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Read with memory always ready and beats returned back-to-back right after acceptance.
  task automatic rd_burst(input string tag, input logic [31:0] a, input logic [7:0] s);
    logic [31:0]  la;
    logic [7:0]   b;
    logic [255:0] e;
    la = {a[31:5], 5'b0};
    chk({tag, "_idle"}, 256'(bmem_read), 256'(0));
    line_addr  = a;
    line_read  = 1'b1;
    bmem_ready = 1'b1;
    step();
    chk({tag, "_cmd"}, 256'({bmem_read, bmem_addr}), 256'({1'b1, la}));
    step();
    e = '0;
    for (int i = 0; i < 4; i++) begin
      b = s + 8'(i);
      bmem_rvalid = 1'b1;
      bmem_raddr  = la;
      bmem_rdata  = pat(b);
      e[64*i +: 64] = pat(b);
      step();
    end
    bmem_rvalid = 1'b0;
    chk({tag, "_resp"}, 256'(line_resp), 256'(1));
    chk({tag, "_line"}, line_rdata, e);
    step();
    line_read = 1'b0;
    chk({tag, "_resp_pulse"}, 256'(line_resp), 256'(0));
  endtask

  initial begin
    logic [255:0] line1, line3, wl, wl3, wl4;
    int rb0, wb0;

    rst = 1'b1;
    line_addr = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_resp",   256'(line_resp),  256'(0));
    chk("rst_read",   256'(bmem_read),  256'(0));
    chk("rst_write",  256'(bmem_write), 256'(0));
    chk("rst_addr",   256'(bmem_addr),  256'(0));
    chk("rst_wdata",  256'(bmem_wdata), 256'(0));
    chk("rst_rdata",  line_rdata,       256'(0));
    step();
    step();
    rst = 1'b1;
    step();

    // Read, ready high, beats on cycles 4..7.
    rb0 = rd_bursts;
    line_addr = 32'h1234_5678; line_read = 1'b1; bmem_ready = 1'b1;
    step();
    chk("t1_read_c1", 256'(bmem_read), 256'(1));
    chk("t1_addr_c1", 256'(bmem_addr), 256'(32'h1234_5660));
    step();
    chk("t1_read_c2", 256'(bmem_read), 256'(0));
    step();
    step();
    line1 = {pat(8'h33), pat(8'h22), pat(8'h11), pat(8'h00)};
    for (int i = 0; i < 4; i++) begin
      chk("t1_no_early_resp", 256'(line_resp), 256'(0));
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h1234_5660;
      bmem_rdata  = line1[64*i +: 64];
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t1_resp_c8", 256'(line_resp), 256'(1));
    chk("t1_line", line_rdata, line1);
    step();
    line_read = 1'b0;
    chk("t1_resp_c9", 256'(line_resp), 256'(0));
    step();
    step();
    chk("t1_no_reissue", 256'(bmem_read), 256'(0));
    chk("t1_one_burst", 256'(rd_bursts - rb0), 256'(1));

    // Write with ready low in cycle 2.
    wb0 = wr_beats;
    wl = {pat(8'hD3), pat(8'hD2), pat(8'hD1), pat(8'hD0)};
    line_addr = 32'hABCD_EF1F; line_write = 1'b1; line_wdata = wl; bmem_ready = 1'b1;
    step();
    chk("t2_write_c1", 256'(bmem_write), 256'(1));
    chk("t2_addr_c1", 256'(bmem_addr), 256'(32'hABCD_EF00));
    chk("t2_beat_c1", 256'(bmem_wdata), 256'(pat(8'hD0)));
    step();
    bmem_ready = 1'b0;
    chk("t2_beat_c2", 256'(bmem_wdata), 256'(pat(8'hD1)));
    step();
    bmem_ready = 1'b1;
    line_wdata = ~wl;
    chk("t2_beat_c3", 256'(bmem_wdata), 256'(pat(8'hD1)));
    step();
    chk("t2_beat_c4", 256'(bmem_wdata), 256'(pat(8'hD2)));
    step();
    chk("t2_beat_c5", 256'(bmem_wdata), 256'(pat(8'hD3)));
    chk("t2_no_early_resp", 256'(line_resp), 256'(0));
    step();
    chk("t2_resp_c6", 256'(line_resp), 256'(1));
    chk("t2_write_low_c6", 256'(bmem_write), 256'(0));
    chk("t2_four_beats", 256'(wr_beats - wb0), 256'(4));
    chk("t2_rdata_kept", line_rdata, line1);
    step();
    line_write = 1'b0;
    step();

    // Read and write together: read first, stray beat ignored, then held write runs.
    wl3 = {pat(8'hA3), pat(8'hA2), pat(8'hA1), pat(8'hA0)};
    line3 = {pat(8'hE3), pat(8'hE2), pat(8'hE1), pat(8'hE0)};
    line_addr = 32'h0000_1040; line_read = 1'b1; line_write = 1'b1; line_wdata = wl3;
    step();
    chk("t3_read_first", 256'({bmem_read, bmem_write}), 256'(2'b10));
    step();
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_1040; bmem_rdata = line3[63:0];
    step();
    bmem_raddr = 32'h0000_2040; bmem_rdata = '1;
    step();
    for (int i = 1; i < 4; i++) begin
      bmem_raddr = 32'h0000_1040;
      bmem_rdata = line3[64*i +: 64];
      step();
    end
    bmem_rvalid = 1'b0;
    chk("t3_resp", 256'(line_resp), 256'(1));
    chk("t3_line_filtered", line_rdata, line3);
    wb0 = wr_beats;
    step();
    line_read = 1'b0;
    chk("t3_idle_gap", 256'({bmem_read, bmem_write}), 256'(0));
    step();
    chk("t3_write_after", 256'(bmem_write), 256'(1));
    chk("t3_wbeat0", 256'(bmem_wdata), 256'(pat(8'hA0)));
    step();
    step();
    step();
    chk("t3_wbeat3", 256'(bmem_wdata), 256'(pat(8'hA3)));
    step();
    chk("t3_wr_resp", 256'(line_resp), 256'(1));
    chk("t3_wr_beats", 256'(wr_beats - wb0), 256'(4));
    chk("t3_rdata_kept", line_rdata, line3);
    step();
    line_write = 1'b0;
    step();

    // Reset during write beat 2.
    wb0 = wr_beats;
    wl4 = {pat(8'hC3), pat(8'hC2), pat(8'hC1), pat(8'hC0)};
    line_addr = 32'h0000_0F00; line_write = 1'b1; line_wdata = wl4; bmem_ready = 1'b1;
    step();
    step();
    step();
    chk("t4_beat2", 256'(bmem_wdata), 256'(pat(8'hC2)));
    rst = 1'b0;
    line_write = 1'b0;
    #1;
    chk("t4_rst_write", 256'(bmem_write), 256'(0));
    chk("t4_rst_wdata", 256'(bmem_wdata), 256'(0));
    chk("t4_rst_addr",  256'(bmem_addr),  256'(0));
    chk("t4_rst_rdata", line_rdata,       256'(0));
    chk("t4_rst_resp",  256'(line_resp),  256'(0));
    step();
    step();
    rst = 1'b1;
    chk("t4_two_beats", 256'(wr_beats - wb0), 256'(2));
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0000; bmem_rdata = '1;
    step();
    step();
    step();
    bmem_rvalid = 1'b0;
    chk("t4_stray_ignored", line_rdata, 256'(0));
    chk("t4_stray_resp", 256'({line_resp, bmem_read, bmem_write}), 256'(0));
    rd_burst("t4_rd", 32'h0000_0080, 8'h40);

    // Back-to-back reads.
    rb0 = rd_bursts;
    rd_burst("t5_a", 32'h0000_1100, 8'h50);
    step();
    rd_burst("t5_b", 32'h0000_113F, 8'h60);
    step();
    step();
    chk("t5_two_bursts", 256'(rd_bursts - rb0), 256'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
